dmem_arbiter: RTL

Two-requester arbiter sharing the single data_mem port between the core load/store path (requester C) and a debug/loader port (requester D). Round-robin grant each cycle, with an optional debug lock for back-to-back bursts. Read data is returned registered, one cycle after grant. Drives core_stall so the top level can hold the program counter enable low while the core's access is pending.

---
 rtl/dmem_arbiter_pkg.sv | 12 +
 rtl/dmem_arbiter_rr_arb2.sv | 32 +++
 rtl/dmem_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: lock FSM states and requester indices.
package dmem_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int REQ_C = 0;
    localparam int REQ_D = 1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant; the priority pointer moves to the loser on every
// granted cycle. freeze suppresses all grants and holds the pointer.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       freeze,
    output logic [1:0] gnt
);

    logic prio_d;  // 1: requester D wins a tie, 0: requester C wins

    always_comb begin
        gnt = '0;
        if (!freeze) begin
            if (req[REQ_C] && (!req[REQ_D] || !prio_d))
                gnt[REQ_C] = 1'b1;
            else if (req[REQ_D])
                gnt[REQ_D] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            prio_d <= 1'b0;
        else if (!freeze && (|gnt))
            prio_d <= gnt[REQ_C];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data_mem port between the core (C) and debug/loader (D) requesters,
// with a debug lock for exclusive bursts and registered per-requester read return.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              core_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_lock,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_e state;
    logic       locked;
    logic [1:0] arb_gnt;

    assign locked = (state == ARB_LOCKED);

    rr_arb2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    ({d_req, c_req}),
        .freeze (locked),
        .gnt    (arb_gnt)
    );

    // While locked the round-robin is bypassed and D owns the port outright.
    assign c_gnt      = arb_gnt[REQ_C];
    assign d_gnt      = locked ? d_req : arb_gnt[REQ_D];
    assign core_stall = c_req & ~c_gnt;

    always_ff @(posedge clk) begin
        if (reset)
            state <= ARB_IDLE;
        else begin
            case (state)
                ARB_IDLE:   if (d_gnt && d_lock) state <= ARB_LOCKED;
                ARB_LOCKED: if (!d_lock)         state <= ARB_IDLE;
                default:                         state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        m_read  = 1'b0;
        m_write = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_read  = ~c_we;
            m_write = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (d_gnt) begin
            m_read  = ~d_we;
            m_write = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    // rdata only moves on a granted read, so it holds between returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_rvalid <= 1'b0;
            c_rdata  <= '0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
        end else begin
            c_rvalid <= c_gnt & ~c_we;
            d_rvalid <= d_gnt & ~d_we;
            if (c_gnt && !c_we) c_rdata <= m_rdata;
            if (d_gnt && !d_we) d_rdata <= m_rdata;
        end
    end

endmodule
